control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have port CLK, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port op, input, 4 bits: opcode from datapath, sampled only in DECODE.
REQ-004 SHALL have port cmpRst, input, 2 bits: comparator result (00 equal, 01 less, 10 greater, 11 reserved, treated as not-equal).
REQ-005 SHALL have datapath control outputs: IRWrite 1, ALUSrcA 1 (0=PC, 1=A), ALUSrcB 1 (0=B, 1=imm), ALUOp 3, writeEnable 1, DOrS 1, memEnableWrite 1, memEnableRead 1, PCWriteEnable 1, PCSource 1 (0=PC+2, 1=ALUOut), regDataWrite 3, loadInst 1, memAddrSel 1 (0=PC, 1=ALUOut), numBits 2, immShift 2.
REQ-006 SHALL have port state, output, 3 bits: current FSM state encoding.

Function
REQ-007 SHALL be a Moore FSM; outputs decode from state and the latched opcode register opReg only.
REQ-008 SHALL use states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; codes 6-7 SHALL return to FETCH next cycle with all outputs 0.
REQ-009 Every output not named active in a state SHALL be 0.
REQ-010 FETCH: memAddrSel=0, memEnableRead=1, IRWrite=1, PCWriteEnable=1, PCSource=0; next DECODE.
REQ-011 DECODE: opReg<=op at clock edge; no outputs active; next EXEC.
REQ-012 Opcodes 0x0-0x7 (ALU reg): EXEC ALUSrcA=1, ALUSrcB=0, ALUOp=opReg[2:0]; WB writeEnable=1, DOrS=1, regDataWrite=0; then FETCH.
REQ-013 0x8 ADDI: EXEC ALUSrcA=1, ALUSrcB=1, ALUOp=0, numBits=2; WB writeEnable=1, regDataWrite=0.
REQ-014 0x9 LI: EXEC numBits=2, immShift=1; WB writeEnable=1, regDataWrite=3.
REQ-015 0xA LOAD: EXEC ALUSrcA=1, ALUSrcB=1, ALUOp=0; MEM memAddrSel=1, memEnableRead=1, loadInst=1; WB writeEnable=1, regDataWrite=1 (5 cycles total).
REQ-016 0xB STORE: EXEC as LOAD; MEM memAddrSel=1, memEnableWrite=1; next FETCH (4 cycles).
REQ-017 0xC CMP: EXEC ALUSrcA=1, ALUSrcB=0; WB writeEnable=1, regDataWrite=4.
REQ-018 0xD BEQ: EXEC ALUSrcA=0, ALUSrcB=1, ALUOp=0, PCSource=1, PCWriteEnable=1 only when cmpRst==00; next FETCH (3 cycles).
REQ-019 0xE JAL: EXEC ALUSrcA=0, ALUSrcB=1, PCSource=1, PCWriteEnable=1, writeEnable=1, regDataWrite=2; next FETCH.
REQ-020 memEnableWrite and memEnableRead SHALL never both be 1; PCWriteEnable SHALL be 1 at most once per instruction except JAL/BEQ-taken (twice).
REQ-021 op changes outside DECODE SHALL not affect the current instruction.

Reset
REQ-022 reset=1 SHALL force state=FETCH, opReg=0 immediately, all outputs 0 except FETCH outputs after release.
REQ-023 Reset asserted mid-instruction (any state incl. MEM with memEnableWrite=1) SHALL deassert memEnableWrite and writeEnable within the same cycle, asynchronously.
REQ-024 First rising edge after reset release SHALL execute FETCH outputs (FETCH is visible during reset release cycle).

Configuration
REQ-025 Macro CU_HALT_EN defined: opcode 0xF goes DECODE->HALT; HALT holds all outputs 0 until reset.
REQ-026 CU_HALT_EN undefined: opcode 0xF is NOP, DECODE->FETCH (2 cycles), HALT state unreachable.

Verification
REQ-027 Reset, op=0x0 in DECODE -> state seq 0,1,2,4,0; WB writeEnable=1, regDataWrite=0; EXEC ALUOp=0.
REQ-028 op=0xA -> seq 0,1,2,3,4,0; MEM memAddrSel=1, memEnableRead=1, loadInst=1; WB regDataWrite=1.
REQ-029 op=0xD, cmpRst=00 -> EXEC PCWriteEnable=1, PCSource=1; repeat with cmpRst=10 -> PCWriteEnable=0 in EXEC.
REQ-030 op=0xB, assert reset in MEM -> memEnableWrite drops to 0 same cycle, state=0.
REQ-031 op=0xF with CU_HALT_EN -> state=5 held 10 cycles, all outputs 0; without macro -> seq 0,1,0.
REQ-032 op toggled 0x0->0xA during EXEC -> instruction completes as ALU type (no MEM state).

Source files
------------

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : control_unit
//  Purpose  : Multi-cycle Moore control FSM for a 16-bit style datapath.
//             Sequences FETCH -> DECODE -> EXEC [-> MEM] [-> WB] -> FETCH
//             and decodes datapath control strobes from the current state
//             and the opcode latched during DECODE.
//
//  Ports    :
//    CLK            in   1  clock, rising edge active
//    reset          in   1  asynchronous active-high reset
//    op             in   4  opcode from datapath (sampled in DECODE only)
//    cmpRst         in   2  comparator result: 00 eq, 01 lt, 10 gt, 11 rsvd
//    IRWrite        out  1  instruction register load
//    ALUSrcA        out  1  ALU A operand select (0=PC, 1=A)
//    ALUSrcB        out  1  ALU B operand select (0=B, 1=imm)
//    ALUOp          out  3  ALU operation
//    writeEnable    out  1  register file write enable
//    DOrS           out  1  destination select
//    memEnableWrite out  1  memory write strobe
//    memEnableRead  out  1  memory read strobe
//    PCWriteEnable  out  1  program counter load
//    PCSource       out  1  PC source (0=PC+2, 1=ALUOut)
//    regDataWrite   out  3  register write-data mux select
//    loadInst       out  1  load-data capture strobe
//    memAddrSel     out  1  memory address select (0=PC, 1=ALUOut)
//    numBits        out  2  immediate width select
//    immShift       out  2  immediate shift select
//    state          out  3  current FSM state encoding
//
//  Build option : define CU_HALT_EN to make opcode 0xF enter a terminal HALT
//                 state; without it opcode 0xF is a two-cycle NOP.
//
//  Revision : 1.0  initial release
// ============================================================================
module control_unit (
    input  logic       CLK,
    input  logic       reset,
    input  logic [3:0] op,
    input  logic [1:0] cmpRst,
    output logic       IRWrite,
    output logic       ALUSrcA,
    output logic       ALUSrcB,
    output logic [2:0] ALUOp,
    output logic       writeEnable,
    output logic       DOrS,
    output logic       memEnableWrite,
    output logic       memEnableRead,
    output logic       PCWriteEnable,
    output logic       PCSource,
    output logic [2:0] regDataWrite,
    output logic       loadInst,
    output logic       memAddrSel,
    output logic [1:0] numBits,
    output logic [1:0] immShift,
    output logic [2:0] state
);

    // ------------------------------------------------------------------------
    // State encoding (codes 6 and 7 are illegal and recover to FETCH)
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    // ------------------------------------------------------------------------
    // Opcodes (0x0-0x7 are register-register ALU operations)
    // ------------------------------------------------------------------------
    localparam logic [3:0] c_OP_ADDI  = 4'h8;
    localparam logic [3:0] c_OP_LI    = 4'h9;
    localparam logic [3:0] c_OP_LOAD  = 4'hA;
    localparam logic [3:0] c_OP_STORE = 4'hB;
    localparam logic [3:0] c_OP_CMP   = 4'hC;
    localparam logic [3:0] c_OP_BEQ   = 4'hD;
    localparam logic [3:0] c_OP_JAL   = 4'hE;
    localparam logic [3:0] c_OP_HALT  = 4'hF;

    // Register write-data mux selections
    localparam logic [2:0] c_RDW_ALU  = 3'd0;
    localparam logic [2:0] c_RDW_MEM  = 3'd1;
    localparam logic [2:0] c_RDW_LINK = 3'd2;
    localparam logic [2:0] c_RDW_IMM  = 3'd3;
    localparam logic [2:0] c_RDW_CMP  = 3'd4;

    localparam logic [1:0] c_CMP_EQ   = 2'b00;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t     state_q;
    state_t     state_d;
    logic [3:0] opReg_q;
    logic [3:0] opReg_d;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            opReg_q <= 4'h0;
        end else begin
            state_q <= state_d;
            opReg_q <= opReg_d;
        end
    end

    assign state = state_q;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = S_FETCH;
        opReg_d = opReg_q;

        case (state_q)
            S_FETCH: begin
                state_d = S_DECODE;
            end

            S_DECODE: begin
                // The opcode is captured here and nowhere else, so later
                // changes on op cannot disturb the instruction in flight.
                opReg_d = op;
                if (op == c_OP_HALT) begin
`ifdef CU_HALT_EN
                    state_d = S_HALT;
`else
                    state_d = S_FETCH;
`endif
                end else begin
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                case (opReg_q)
                    c_OP_LOAD,
                    c_OP_STORE: state_d = S_MEM;
                    c_OP_BEQ,
                    c_OP_JAL,
                    c_OP_HALT:  state_d = S_FETCH;
                    default:    state_d = S_WB;
                endcase
            end

            S_MEM: begin
                // Stores retire straight from MEM; loads still need WB.
                if (opReg_q == c_OP_LOAD) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_FETCH;
                end
            end

            S_WB: begin
                state_d = S_FETCH;
            end

            S_HALT: begin
`ifdef CU_HALT_EN
                // Terminal: only reset leaves HALT.
                state_d = S_HALT;
`else
                state_d = S_FETCH;
`endif
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------------
    // Outputs are qualified with reset so that every strobe (in particular
    // memEnableWrite and writeEnable) drops in the same cycle reset rises,
    // without waiting for the state register to settle.
    always_comb begin
        IRWrite        = 1'b0;
        ALUSrcA        = 1'b0;
        ALUSrcB        = 1'b0;
        ALUOp          = 3'd0;
        writeEnable    = 1'b0;
        DOrS           = 1'b0;
        memEnableWrite = 1'b0;
        memEnableRead  = 1'b0;
        PCWriteEnable  = 1'b0;
        PCSource       = 1'b0;
        regDataWrite   = 3'd0;
        loadInst       = 1'b0;
        memAddrSel     = 1'b0;
        numBits        = 2'd0;
        immShift       = 2'd0;

        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    memAddrSel    = 1'b0;
                    memEnableRead = 1'b1;
                    IRWrite       = 1'b1;
                    PCWriteEnable = 1'b1;
                    PCSource      = 1'b0;
                end

                S_EXEC: begin
                    if (!opReg_q[3]) begin
                        ALUSrcA = 1'b1;
                        ALUSrcB = 1'b0;
                        ALUOp   = opReg_q[2:0];
                    end else begin
                        case (opReg_q)
                            c_OP_ADDI: begin
                                ALUSrcA = 1'b1;
                                ALUSrcB = 1'b1;
                                numBits = 2'd2;
                            end
                            c_OP_LI: begin
                                numBits  = 2'd2;
                                immShift = 2'd1;
                            end
                            c_OP_LOAD,
                            c_OP_STORE: begin
                                // Address = A + imm
                                ALUSrcA = 1'b1;
                                ALUSrcB = 1'b1;
                            end
                            c_OP_CMP: begin
                                ALUSrcA = 1'b1;
                                ALUSrcB = 1'b0;
                            end
                            c_OP_BEQ: begin
                                // Target = PC + imm; the PC is only redirected
                                // on an equal compare (11 counts as not-equal).
                                ALUSrcB = 1'b1;
                                if (cmpRst == c_CMP_EQ) begin
                                    PCSource      = 1'b1;
                                    PCWriteEnable = 1'b1;
                                end
                            end
                            c_OP_JAL: begin
                                // Link register gets the return address in the
                                // same cycle the PC jumps.
                                ALUSrcB       = 1'b1;
                                PCSource      = 1'b1;
                                PCWriteEnable = 1'b1;
                                writeEnable   = 1'b1;
                                regDataWrite  = c_RDW_LINK;
                            end
                            default: begin
                            end
                        endcase
                    end
                end

                S_MEM: begin
                    if (opReg_q == c_OP_LOAD) begin
                        memAddrSel    = 1'b1;
                        memEnableRead = 1'b1;
                        loadInst      = 1'b1;
                    end else if (opReg_q == c_OP_STORE) begin
                        memAddrSel     = 1'b1;
                        memEnableWrite = 1'b1;
                    end
                end

                S_WB: begin
                    if (!opReg_q[3]) begin
                        writeEnable  = 1'b1;
                        DOrS         = 1'b1;
                        regDataWrite = c_RDW_ALU;
                    end else begin
                        case (opReg_q)
                            c_OP_ADDI: begin
                                writeEnable  = 1'b1;
                                regDataWrite = c_RDW_ALU;
                            end
                            c_OP_LI: begin
                                writeEnable  = 1'b1;
                                regDataWrite = c_RDW_IMM;
                            end
                            c_OP_LOAD: begin
                                writeEnable  = 1'b1;
                                regDataWrite = c_RDW_MEM;
                            end
                            c_OP_CMP: begin
                                writeEnable  = 1'b1;
                                regDataWrite = c_RDW_CMP;
                            end
                            default: begin
                            end
                        endcase
                    end
                end

                // DECODE, HALT and illegal codes drive nothing.
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_control_unit
//  Purpose  : Directed self-checking bench for control_unit. Each step pushes
//             the expected state/outputs to a scoreboard queue and pops them
//             when the DUT produces the corresponding cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_control_unit;

    typedef struct packed {
        logic       IRWrite;
        logic       ALUSrcA;
        logic       ALUSrcB;
        logic [2:0] ALUOp;
        logic       writeEnable;
        logic       DOrS;
        logic       memEnableWrite;
        logic       memEnableRead;
        logic       PCWriteEnable;
        logic       PCSource;
        logic [2:0] regDataWrite;
        logic       loadInst;
        logic       memAddrSel;
        logic [1:0] numBits;
        logic [1:0] immShift;
    } outs_t;

    logic       CLK = 1'b0;
    logic       reset;
    logic [3:0] op;
    logic [1:0] cmpRst;

    logic       IRWrite, ALUSrcA, ALUSrcB, writeEnable, DOrS;
    logic       memEnableWrite, memEnableRead, PCWriteEnable, PCSource;
    logic       loadInst, memAddrSel;
    logic [2:0] ALUOp, regDataWrite, state;
    logic [1:0] numBits, immShift;

    control_unit dut (
        .CLK            (CLK),
        .reset          (reset),
        .op             (op),
        .cmpRst         (cmpRst),
        .IRWrite        (IRWrite),
        .ALUSrcA        (ALUSrcA),
        .ALUSrcB        (ALUSrcB),
        .ALUOp          (ALUOp),
        .writeEnable    (writeEnable),
        .DOrS           (DOrS),
        .memEnableWrite (memEnableWrite),
        .memEnableRead  (memEnableRead),
        .PCWriteEnable  (PCWriteEnable),
        .PCSource       (PCSource),
        .regDataWrite   (regDataWrite),
        .loadInst       (loadInst),
        .memAddrSel     (memAddrSel),
        .numBits        (numBits),
        .immShift       (immShift),
        .state          (state)
    );

    always #5 CLK = ~CLK;

    outs_t w_obs;
    assign w_obs = {IRWrite, ALUSrcA, ALUSrcB, ALUOp, writeEnable, DOrS,
                    memEnableWrite, memEnableRead, PCWriteEnable, PCSource,
                    regDataWrite, loadInst, memAddrSel, numBits, immShift};

    // Scoreboard
    string      q_tag[$];
    logic [2:0] q_st[$];
    outs_t      q_out[$];
    outs_t      q_mask[$];

    int n_cmp  = 0;
    int n_fail = 0;

    outs_t r_zero;
    outs_t r_all;
    outs_t r_fetch;
    outs_t e;
    outs_t m;

    task automatic push_exp(input string tag, input logic [2:0] st,
                            input outs_t o, input outs_t msk);
        q_tag.push_back(tag);
        q_st.push_back(st);
        q_out.push_back(o);
        q_mask.push_back(msk);
    endtask

    task automatic pop_cmp();
        string      tag;
        logic [2:0] st;
        outs_t      o;
        outs_t      msk;
        tag = q_tag.pop_front();
        st  = q_st.pop_front();
        o   = q_out.pop_front();
        msk = q_mask.pop_front();
        n_cmp++;
        assert (state === st && (w_obs & msk) === (o & msk)) else begin
            n_fail++;
            $error("FAIL %s: got state=%0d outs=%06h, want state=%0d outs=%06h (mask %06h)",
                   tag, state, w_obs, st, o, msk);
        end
    endtask

    // Expect the given values one clock later (sampled on the falling edge).
    task automatic step(input string tag, input logic [2:0] st,
                        input outs_t o, input outs_t msk);
        push_exp(tag, st, o, msk);
        @(posedge CLK);
        @(negedge CLK);
        pop_cmp();
    endtask

    // Expect the given values right now (combinational response).
    task automatic now(input string tag, input logic [2:0] st, input outs_t o);
        push_exp(tag, st, o, r_all);
        #1;
        pop_cmp();
    endtask

    initial begin
        r_zero  = '0;
        r_all   = '1;
        r_fetch = '0;
        r_fetch.memEnableRead = 1'b1;
        r_fetch.IRWrite       = 1'b1;
        r_fetch.PCWriteEnable = 1'b1;

        reset  = 1'b1;
        op     = 4'h0;
        cmpRst = 2'b00;

        // Held in reset across a clock edge: FETCH state, all outputs low.
        @(negedge CLK);
        now("reset", 3'd0, r_zero);
        reset = 1'b0;
        now("release_fetch", 3'd0, r_fetch);

        // ALU op 0x0: 0,1,2,4,0
        op = 4'h0;
        step("alu0_decode", 3'd1, r_zero, r_all);
        e = '0; e.ALUSrcA = 1'b1; e.ALUOp = 3'd0;
        step("alu0_exec", 3'd2, e, r_all);
        e = '0; e.writeEnable = 1'b1; e.DOrS = 1'b1;
        step("alu0_wb", 3'd4, e, r_all);
        step("alu0_fetch", 3'd0, r_fetch, r_all);

        // ALU op 0x5 with op switched to LOAD during EXEC: no MEM state.
        op = 4'h5;
        step("alu5_decode", 3'd1, r_zero, r_all);
        e = '0; e.ALUSrcA = 1'b1; e.ALUOp = 3'd5;
        step("alu5_exec", 3'd2, e, r_all);
        op = 4'hA;
        e = '0; e.writeEnable = 1'b1; e.DOrS = 1'b1;
        step("alu5_wb_not_mem", 3'd4, e, r_all);
        step("alu5_fetch", 3'd0, r_fetch, r_all);

        // LOAD 0xA: 0,1,2,3,4,0 (op still 0xA)
        step("load_decode", 3'd1, r_zero, r_all);
        e = '0; e.ALUSrcA = 1'b1; e.ALUSrcB = 1'b1;
        step("load_exec", 3'd2, e, r_all);
        e = '0; e.memAddrSel = 1'b1; e.memEnableRead = 1'b1; e.loadInst = 1'b1;
        step("load_mem", 3'd3, e, r_all);
        e = '0; e.writeEnable = 1'b1; e.regDataWrite = 3'd1;
        step("load_wb", 3'd4, e, r_all);
        step("load_fetch", 3'd0, r_fetch, r_all);

        // BEQ taken
        op = 4'hD; cmpRst = 2'b00;
        step("beq_t_decode", 3'd1, r_zero, r_all);
        e = '0; e.ALUSrcB = 1'b1; e.PCSource = 1'b1; e.PCWriteEnable = 1'b1;
        step("beq_t_exec", 3'd2, e, r_all);
        step("beq_t_fetch", 3'd0, r_fetch, r_all);

        // BEQ not taken (greater, then reserved code); PCSource not checked
        m = r_all; m.PCSource = 1'b0;
        cmpRst = 2'b10;
        step("beq_gt_decode", 3'd1, r_zero, r_all);
        e = '0; e.ALUSrcB = 1'b1;
        step("beq_gt_exec", 3'd2, e, m);
        step("beq_gt_fetch", 3'd0, r_fetch, r_all);
        cmpRst = 2'b11;
        step("beq_rsv_decode", 3'd1, r_zero, r_all);
        step("beq_rsv_exec", 3'd2, e, m);
        step("beq_rsv_fetch", 3'd0, r_fetch, r_all);
        cmpRst = 2'b00;

        // JAL
        op = 4'hE;
        step("jal_decode", 3'd1, r_zero, r_all);
        e = '0; e.ALUSrcB = 1'b1; e.PCSource = 1'b1; e.PCWriteEnable = 1'b1;
        e.writeEnable = 1'b1; e.regDataWrite = 3'd2;
        step("jal_exec", 3'd2, e, r_all);
        step("jal_fetch", 3'd0, r_fetch, r_all);

        // ADDI
        op = 4'h8;
        step("addi_decode", 3'd1, r_zero, r_all);
        e = '0; e.ALUSrcA = 1'b1; e.ALUSrcB = 1'b1; e.numBits = 2'd2;
        step("addi_exec", 3'd2, e, r_all);
        e = '0; e.writeEnable = 1'b1;
        step("addi_wb", 3'd4, e, r_all);
        step("addi_fetch", 3'd0, r_fetch, r_all);

        // LI
        op = 4'h9;
        step("li_decode", 3'd1, r_zero, r_all);
        e = '0; e.numBits = 2'd2; e.immShift = 2'd1;
        step("li_exec", 3'd2, e, r_all);
        e = '0; e.writeEnable = 1'b1; e.regDataWrite = 3'd3;
        step("li_wb", 3'd4, e, r_all);
        step("li_fetch", 3'd0, r_fetch, r_all);

        // CMP
        op = 4'hC;
        step("cmp_decode", 3'd1, r_zero, r_all);
        e = '0; e.ALUSrcA = 1'b1;
        step("cmp_exec", 3'd2, e, r_all);
        e = '0; e.writeEnable = 1'b1; e.regDataWrite = 3'd4;
        step("cmp_wb", 3'd4, e, r_all);
        step("cmp_fetch", 3'd0, r_fetch, r_all);

        // STORE interrupted by reset while writing memory
        op = 4'hB;
        step("store_decode", 3'd1, r_zero, r_all);
        e = '0; e.ALUSrcA = 1'b1; e.ALUSrcB = 1'b1;
        step("store_exec", 3'd2, e, r_all);
        e = '0; e.memAddrSel = 1'b1; e.memEnableWrite = 1'b1;
        step("store_mem", 3'd3, e, r_all);
        reset = 1'b1;
        now("store_async_rst", 3'd0, r_zero);
        @(negedge CLK);
        reset = 1'b0;
        now("store_rst_release", 3'd0, r_fetch);

        // Opcode 0xF
        op = 4'hF;
        step("opf_decode", 3'd1, r_zero, r_all);
`ifdef CU_HALT_EN
        for (int i = 0; i < 10; i++) begin
            step("halt_hold", 3'd5, r_zero, r_all);
        end
        reset = 1'b1;
        now("halt_reset", 3'd0, r_zero);
        @(negedge CLK);
        reset = 1'b0;
        now("halt_release", 3'd0, r_fetch);
`else
        step("nop_fetch", 3'd0, r_fetch, r_all);
        op = 4'h0;
        step("nop_next_decode", 3'd1, r_zero, r_all);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
